// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU,
// branch/jump resolution and the EX/MEM pipeline register.
module execute_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [5:0]      Branch,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            ZeroE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] jalr_sum;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            taken;

    logic            reg_write_d,   reg_write_q;
    logic            mem_write_d,   mem_write_q;
    logic [1:0]      result_src_d,  result_src_q;
    logic [4:0]      rd_d,          rd_q;
    logic [XLEN-1:0] alu_result_d,  alu_result_q;
    logic [XLEN-1:0] write_data_d,  write_data_q;
    logic [XLEN-1:0] pc_plus4_d,    pc_plus4_q;

    // Forwarding reads the registered ALU result, so there is no combinational loop.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        write_data = RD2_E;
        case (ForwardBE)
            2'b01:   write_data = ResultW;
            2'b10:   write_data = alu_result_q;
            default: write_data = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : write_data;

    always_comb begin
        alu_result = '0;
        case (alu_op_e'(ALUControlE))
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLL: alu_result = src_a << src_b[4:0];
            ALU_SRL: alu_result = src_a >> src_b[4:0];
            default: alu_result = '0;
        endcase
    end

    assign ZeroE = (alu_result == '0);

    // Branch compare looks at the register operands, never at SrcB or the ALU.
    assign eq    = (src_a == write_data);
    assign lt_s  = ($signed(src_a) < $signed(write_data));
    assign lt_u  = (src_a < write_data);
    assign taken = |(Branch & {~lt_u, lt_u, ~lt_s, lt_s, ~eq, eq});

    assign PCSrcE    = JumpE | taken;
    assign jalr_sum  = src_a + Imm_Ext_E;
    assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + Imm_Ext_E);

    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        rd_d         = RD_E;
        alu_result_d = alu_result;
        write_data_d = write_data;
        pc_plus4_d   = PCPlus4E;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            rd_q         <= 5'd0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign RD_M       = rd_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed steps plus random traffic, checked against
// an arithmetic reference model of the EX stage and its EX/MEM register.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, ALUSrcE, JumpE, JalrE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [2:0]  ALUControlE;
    logic [5:0]  Branch;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic        PCSrcE, ZeroE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;

    int n_vec = 0;
    int n_err = 0;

    // model of the EX/MEM register contents
    logic        m_rw, m_mw;
    logic [1:0]  m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pc4;

    // comb outputs captured during the last cycle
    logic        cap_pcsrc, cap_zero;
    logic [31:0] cap_target;

    logic [31:0] sweep_exp [8] = '{32'h4, 32'h6, 32'h5, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFA, 32'h0, 32'h8000_0000, 32'h0};

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .Branch(Branch),
        .JumpE(JumpE), .JalrE(JalrE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ZeroE(ZeroE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd,
                                        input logic [31:0] rw, input logic [31:0] am);
        if (sel == 2'd1) return rw;
        if (sel == 2'd2) return am;
        return rd;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int          sa, sb;
        longint unsigned pow2;
        sa   = a;
        sb   = b;
        pow2 = 64'd1 << b[4:0];
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return 32'((64'(a) * pow2) % 64'h1_0000_0000);
            default: return 32'(64'(a) / pow2);
        endcase
    endfunction

    function automatic logic ref_taken(input logic [5:0] br, input logic [31:0] a,
                                       input logic [31:0] b);
        int sa, sb;
        logic cond [6];
        logic t;
        sa = a;
        sb = b;
        cond[0] = (a == b);
        cond[1] = (a != b);
        cond[2] = (sa < sb);
        cond[3] = !(sa < sb);
        cond[4] = (64'(a) < 64'(b));
        cond[5] = !(64'(a) < 64'(b));
        t = 1'b0;
        for (int i = 0; i < 6; i++) if (br[i] && cond[i]) t = 1'b1;
        return t;
    endfunction

    task automatic clear_inputs();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0; ALUControlE = 0;
        Branch = 0; JumpE = 0; JalrE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
        PCE = 0; PCPlus4E = 0; RD_E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    task automatic random_inputs();
        RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 2'($urandom);
        ALUSrcE = 1'($urandom); ALUControlE = 3'($urandom); Branch = 6'($urandom);
        JumpE = 1'($urandom); JalrE = 1'($urandom); RD1_E = $urandom; RD2_E = $urandom;
        Imm_Ext_E = $urandom; PCE = $urandom; PCPlus4E = $urandom; RD_E = 5'($urandom);
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
        if ($urandom_range(0, 3) == 0) RD2_E = RD1_E;
    endtask

    // One instruction: check combinational outputs mid-cycle, then the EX/MEM register.
    task automatic run_cycle();
        logic [31:0] a, wd, b, alu, tgt;
        logic        tk;
        @(negedge clk);
        a   = fwd(ForwardAE, RD1_E, ResultW, m_alu);
        wd  = fwd(ForwardBE, RD2_E, ResultW, m_alu);
        b   = ALUSrcE ? Imm_Ext_E : wd;
        alu = ref_alu(ALUControlE, a, b);
        tk  = ref_taken(Branch, a, wd);
        tgt = JalrE ? ((a + Imm_Ext_E) / 2) * 2 : PCE + Imm_Ext_E;
        chk("pcsrc", 32'(PCSrcE), 32'(JumpE | tk));
        chk("pctarget", PCTargetE, tgt);
        chk("zero", 32'(ZeroE), 32'(alu == 0));
        cap_pcsrc  = PCSrcE;
        cap_target = PCTargetE;
        cap_zero   = ZeroE;
        @(posedge clk);
        #1;
        if (rst) begin
            m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_rd = RD_E;
            m_alu = alu; m_wd = wd; m_pc4 = PCPlus4E;
        end else begin
            m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
        end
        chk("regwrite_m", 32'(RegWriteM), 32'(m_rw));
        chk("memwrite_m", 32'(MemWriteM), 32'(m_mw));
        chk("resultsrc_m", 32'(ResultSrcM), 32'(m_rs));
        chk("rd_m", 32'(RD_M), 32'(m_rd));
        chk("aluresult_m", ALUResultM, m_alu);
        chk("writedata_m", WriteDataM, m_wd);
        chk("pcplus4_m", PCPlus4M, m_pc4);
    endtask

    initial begin
        logic [31:0] e_pc4;
        m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
        clear_inputs();

        // reset with random inputs, M outputs must stay cleared
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            random_inputs();
            run_cycle();
            chk("reset_alu_zero", ALUResultM, 32'h0);
        end
        rst = 1'b1;
        random_inputs();
        e_pc4 = PCPlus4E;
        run_cycle();
        chk("first_after_reset_pc4", PCPlus4M, e_pc4);

        // ALU sweep without forwarding
        clear_inputs();
        RD1_E = 32'h5; RD2_E = 32'hFFFF_FFFF; RegWriteE = 1;
        for (int op = 0; op < 8; op++) begin
            ALUControlE = 3'(op);
            run_cycle();
            chk("alu_sweep", ALUResultM, sweep_exp[op]);
        end

        // forwarding
        clear_inputs();
        RD1_E = 32'd3; RD2_E = 32'd4;
        run_cycle();
        chk("fwd_first_add", ALUResultM, 32'd7);
        ForwardAE = 2'b10; RD1_E = 32'd100; RD2_E = 32'd1;
        run_cycle();
        chk("fwd_a_from_mem", ALUResultM, 32'd8);
        ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'h1234; RD1_E = 32'd1; RD2_E = 32'd9;
        run_cycle();
        chk("fwd_b_wb_data", WriteDataM, 32'h1234);
        chk("fwd_b_wb_sum", ALUResultM, 32'h1235);
        ForwardAE = 2'b11; ForwardBE = 2'b00; RD1_E = 32'd2; RD2_E = 32'd3;
        run_cycle();
        chk("fwd_a_11", ALUResultM, 32'd5);

        // branches
        clear_inputs();
        PCE = 32'h100; Imm_Ext_E = 32'h20; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'h1;
        Branch = 6'b000100; run_cycle();
        chk("blt_taken", 32'(cap_pcsrc), 32'd1);
        chk("blt_target", cap_target, 32'h120);
        Branch = 6'b010000; run_cycle();
        chk("bltu_not_taken", 32'(cap_pcsrc), 32'd0);
        Branch = 6'b001000; run_cycle();
        chk("bge_not_taken", 32'(cap_pcsrc), 32'd0);
        Branch = 6'b100000; run_cycle();
        chk("bgeu_taken", 32'(cap_pcsrc), 32'd1);
        RD1_E = 32'h5; RD2_E = 32'h5;
        Branch = 6'b000001; run_cycle();
        chk("beq_taken", 32'(cap_pcsrc), 32'd1);
        Branch = 6'b000010; run_cycle();
        chk("bne_not_taken", 32'(cap_pcsrc), 32'd0);

        // jumps
        clear_inputs();
        JumpE = 1; PCE = 32'h40; Imm_Ext_E = 32'h8; ResultSrcE = 2'b10; RegWriteE = 1;
        run_cycle();
        chk("jal_pcsrc", 32'(cap_pcsrc), 32'd1);
        chk("jal_target", cap_target, 32'h48);
        JalrE = 1; RD1_E = 32'h101; Imm_Ext_E = 32'h4; PCPlus4E = 32'h2004;
        run_cycle();
        chk("jalr_target", cap_target, 32'h104);
        chk("jalr_pcplus4", PCPlus4M, 32'h2004);

        // store followed by a bubble
        clear_inputs();
        MemWriteE = 1; ALUSrcE = 1; RD1_E = 32'h1000; Imm_Ext_E = 32'h10; RD2_E = 32'hDEAD_BEEF;
        run_cycle();
        chk("store_addr", ALUResultM, 32'h1010);
        chk("store_data", WriteDataM, 32'hDEAD_BEEF);
        chk("store_memwrite", 32'(MemWriteM), 32'd1);
        clear_inputs();
        run_cycle();
        chk("bubble_memwrite", 32'(MemWriteM), 32'd0);

        // random traffic with occasional mid-stream reset
        for (int i = 0; i < 300; i++) begin
            random_inputs();
            rst = ($urandom_range(0, 15) != 0);
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
